// File: rtl/sctrl_pkg.sv
// Shared types and constants for the ping-pong sensor capture controller.
package sctrl_pkg;

  // Controller state, exported for observation on the dbg_state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // nothing captured and capture disabled
    FILL  = 2'd1,  // capturing with no bank full
    HOLD  = 2'd2,  // one bank awaits release; in ping-pong the other fills
    STALL = 2'd3   // no bank is available for writing
  } state_t;

  // Values of sctrl_mode.
  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

endpackage

// File: rtl/sctrl_bank_mem.sv
// Two-bank register file: one synchronous write port, one combinational read
// port. The asynchronous reset zeroes every word, so partial data from an
// interrupted fill is never visible after reset.
module sctrl_bank_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              wbank,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rbank,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Bank select is the MSB of the flat index.
  logic [DATA_W-1:0] mem_q [2*DEPTH];

  // Storage: cleared on reset, written on a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2*DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[{wbank, waddr}] <= wdata;
    end
  end

  assign rdata = mem_q[{rbank, raddr}];

endmodule

// File: rtl/sensor_ctrl_pp.sv
// Sensor capture controller with a two-bank buffer. The sensor fills bank
// wbank while the core reads bank sctrl_bank; each completed bank raises a
// level interrupt that the core clears with a release pulse.
//
// Handshake: a sensor word is accepted on every rising clk edge where
// sensor_en and sensor_ready are both high (sensor_en is the ready, sensor_ready
// the valid); there is no other flow control and a word offered while
// sensor_en is low is dropped (and counted as an overrun in ping-pong STALL).
module sensor_ctrl_pp
  import sctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int OVR_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic              sctrl_mode,
  input  logic              sctrl_release,
  input  logic [ADDR_W-1:0] sctrl_addr,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sctrl_interrupt,
  output logic [DATA_W-1:0] sctrl_out,
  output logic              sctrl_bank,
  output logic [OVR_W-1:0]  sctrl_overrun,
  output logic              sensor_en,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [OVR_W-1:0]  OVR_MAX   = {OVR_W{1'b1}};

  logic              wbank_q, wbank_d;   // bank being filled
  logic              rbank_q, rbank_d;   // bank the core must read
  logic [1:0]        full_q, full_d;     // per-bank "completed, not released"
  logic [ADDR_W-1:0] cnt_q, cnt_d;       // next write address in wbank
  logic [OVR_W-1:0]  ovr_q, ovr_d;       // dropped-sample count
  state_t            state_q, state_d;

  logic cap;   // a sensor word is written this cycle
  logic done;  // that write is the last word of the bank
  logic rel;   // an effective release (interrupt was high)

  assign sensor_en = sctrl_en & ~sctrl_clear & ~full_q[wbank_q];
  assign cap       = sensor_en & sensor_ready;
  assign done      = cap & (cnt_q == LAST_ADDR);
  assign rel       = sctrl_release & full_q[rbank_q];

  assign sctrl_interrupt = full_q[rbank_q];
  assign sctrl_bank      = rbank_q;
  assign sctrl_overrun   = ovr_q;
  assign dbg_state       = state_q;

  // Bank bookkeeping, address counter and overrun counter. A release is
  // applied before a same-cycle completion so the completing bank only
  // becomes the read bank when nothing older is still waiting.
  always_comb begin
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (sctrl_clear) begin
      wbank_d = 1'b0;
      rbank_d = 1'b0;
      full_d  = 2'b00;
      cnt_d   = '0;
      ovr_d   = '0;
    end else begin
      if (rel) begin
        full_d[rbank_q] = 1'b0;
        // Hand the core the other bank if it is already waiting. In single
        // mode this only happens after a mode switch mid ping-pong, and
        // switching still keeps that bank from being stranded.
        if (full_q[~rbank_q]) begin
          rbank_d = ~rbank_q;
        end
      end
      if (cap) begin
        // DEPTH is a power of two, so the increment wraps on its own; in
        // single mode the counter is therefore already 0 when the bank
        // is re-armed by release.
        cnt_d = cnt_q + ADDR_W'(1);
      end
      if (done) begin
        full_d[wbank_q] = 1'b1;
        if (!full_d[~wbank_q]) begin
          rbank_d = wbank_q;
        end
        if (sctrl_mode == MODE_PINGPONG) begin
          wbank_d = ~wbank_q;
        end
      end
      if ((state_q == STALL) && (sctrl_mode == MODE_PINGPONG) &&
          sctrl_en && sensor_ready && (ovr_q != OVR_MAX)) begin
        ovr_d = ovr_q + OVR_W'(1);
      end
    end
  end

  // Next state follows the bank flags: STALL when the write bank is full,
  // HOLD when some other bank awaits release, FILL once capture started.
  always_comb begin
    state_d = state_q;
    if (sctrl_clear) begin
      state_d = IDLE;
    end else if (full_d == 2'b00) begin
      state_d = ((state_q == IDLE) && !sctrl_en) ? IDLE : FILL;
    end else if (full_d[wbank_d]) begin
      state_d = STALL;
    end else begin
      state_d = HOLD;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= 2'b00;
      cnt_q   <= '0;
      ovr_q   <= '0;
      state_q <= IDLE;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
    end
  end

  sctrl_bank_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rstn),
    .we    (cap),
    .wbank (wbank_q),
    .waddr (cnt_q),
    .wdata (sensor_out),
    .rbank (rbank_q),
    .raddr (sctrl_addr),
    .rdata (sctrl_out)
  );

endmodule

// File: doc/sensor_ctrl_pp.md
Name: sensor_ctrl_pp

Overview:
Parametrised successor of the high-speed sensor controller. It captures sensor words into a two-bank buffer, so the core can read one completed bank while the sensor fills the other. It supports a legacy single-shot mode and a continuous ping-pong mode, and counts dropped samples when both banks are full. It sits between the sensor and the core/DMA read port and raises a level interrupt per completed bank.

Parameters:
DATA_W, 32, sensor/core data width
DEPTH, 64, words per bank (power of two, >=2)
ADDR_W, $clog2(DEPTH), bank word address width
OVR_W, 16, width of saturating overrun counter

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock domain, asynchronous and active-low
sctrl_en  in  1  capture enable
sctrl_clear  in  1  synchronous clear of counters/flags/overrun (memory untouched)
sctrl_mode  in  1  0 = single-shot, 1 = ping-pong continuous
sctrl_release  in  1  one-cycle pulse: core finished reading bank sctrl_bank
sctrl_addr  in  ADDR_W  read address within bank sctrl_bank
sensor_ready  in  1  sensor word valid
sensor_out  in  DATA_W  sensor word
sctrl_interrupt  out  1  level: a completed bank awaits release
sctrl_out  out  DATA_W  mem[sctrl_bank][sctrl_addr], combinational
sctrl_bank  out  1  bank the core must read
sctrl_overrun  out  OVR_W  saturating count of dropped samples
sensor_en  out  1  capture request to sensor

Behaviour:
- Reset: wbank=0, sctrl_bank=0, counter=0, full[1:0]=0, overrun=0, all memory words=0. Outputs: sctrl_interrupt=0, sensor_en=0, sctrl_out=0, sctrl_overrun=0.
- sensor_en = sctrl_en & ~sctrl_clear & ~full[wbank].
- Capture on a cycle with sensor_en & sensor_ready: mem[wbank][counter] <= sensor_out; counter increments and wraps DEPTH-1 -> 0. Write latency 1 cycle. Read latency 0.
- Bank completion happens on a capture at counter==DEPTH-1: full[wbank]<=1 and sctrl_bank<=wbank.
  - Mode 1: wbank<=~wbank on the same edge.
  - Mode 0: wbank is held, so sensor_en drops until release.
- sctrl_interrupt = full[sctrl_bank].
- Release: clears full[sctrl_bank].
  - In mode 1, if the other bank is also full, sctrl_bank <= ~sctrl_bank on the same edge and the interrupt stays high.
  - In mode 0, release re-arms the same bank and counter restarts from 0.
  - Release while the interrupt is low is ignored.
- States (enum in package):
  - IDLE: no bank full, sctrl_en=0.
  - FILL: capturing, no bank full.
  - HOLD: one bank full; in mode 1 the other bank is filling.
  - STALL: both banks full in mode 1, or the bank is full in mode 0.
- Transitions:
  - IDLE->FILL on sctrl_en.
  - FILL->HOLD on completion (mode 1).
  - FILL->STALL on completion (mode 0).
  - HOLD->STALL on completion while unreleased.
  - HOLD->FILL on release.
  - STALL->HOLD (mode 1) or STALL->FILL (mode 0) on release.
  - Any state->IDLE on clear.
- Overrun: in STALL with mode 1, each cycle with sctrl_en & sensor_ready increments the counter, saturating at 2^OVR_W-1. Mode 0 never counts.
- Simultaneous completion and release, same cycle:
  - The release applies to the old sctrl_bank first.
  - Completion then sets full[wbank] and, if no other bank remains full, makes wbank the new sctrl_bank.
  - No sample is lost and the interrupt stays high.
- Clear has priority over capture, release and completion. Clear sets counter=0, full=0, wbank=0, sctrl_bank=0, overrun=0, and sensor_en=0 in the same cycle.
- A mode change takes effect at the next completion or release. Changing mode mid-fill never corrupts counter.
- Asynchronous reset mid-fill discards partial data; the state after reset is exactly the reset state.

Decomposition:
- sctrl_pkg: state enum (IDLE, FILL, HOLD, STALL), mode constants (MODE_SINGLE=0, MODE_PINGPONG=1).
- Sub-module sctrl_bank_mem: 2xDEPTHxDATA_W register file with async-reset clear, one write port and one combinational read port, parameters DATA_W/DEPTH.
- Control FSM and counters live in the top module.

Test Plan:
- Single-shot legacy behaviour (mode 0, DEPTH=8): write 1..8 -> interrupt high after 8th capture, sensor_en=0, sctrl_bank=0, reads of addr 0..7 return 1..8; release -> interrupt low, next capture lands at addr 0.
- Ping-pong fill (mode 1, DEPTH=8): stream 1..16 with no release -> bank0 holds 1..8, bank1 holds 9..16, STALL, sensor_en=0; 3 further ready cycles -> sctrl_overrun=3.
- Release chain: from the previous end state, release -> sctrl_bank=1, interrupt stays high; release again -> interrupt low, capture resumes into bank0 at addr 0.
- Simultaneous event: release pulsed on the same cycle as bank1's final capture -> no dropped sample, sctrl_bank=1, interrupt high, overrun=0.
- Clear mid-fill (capture 5 words then sctrl_clear with sensor_ready high) -> sensor_en=0 that cycle, mem unchanged at addr 5, counter=0, overrun=0, interrupt=0.
- Async reset with both banks full -> all outputs 0, memory reads 0, sensor_en=0 until sctrl_en is reasserted.
